divider_arbiter: RTL
====================

# divider_arbiter

Shares one `non_restoring_divider` instance between `NUM_REQ` requesters using round-robin arbitration. Sequences the divider's start/done protocol, short-circuits the trivial cases (divide-by-zero, dividend < divisor) without occupying the divider, and returns a tagged result through a valid/ready handshake. It sits between multiple integer execution clients and the shared divider datapath.

## Interface

- `DATA_WIDTH`, 16: operand width; power of 2.
- `NUM_REQ`, 4: number of requesters; ≥2.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: asynchronous active-low reset.
- `clk_en_i` in 1: clock enable; when low, all state including the divider instance holds.
- `req_valid_i` in NUM_REQ: per-requester request valid.
- `req_dividend_i` in NUM_REQ×DATA_WIDTH: packed array of per-requester dividends.
- `req_divisor_i` in NUM_REQ×DATA_WIDTH: packed array of per-requester divisors.
- `req_ready_o` out NUM_REQ: one-hot grant; the request is accepted when valid and ready are both high.
- `resp_valid_o` out 1: result valid.
- `resp_ready_i` in 1: consumer accepts the result.
- `resp_id_o` out $clog2(NUM_REQ): index of the requester that owns the result.
- `quotient_o` out DATA_WIDTH: quotient.
- `remainder_o` out DATA_WIDTH: remainder.
- `div_by_zero_o` out 1: the divisor was zero.
- `busy_o` out 1: high in every state except IDLE.

## Operation

- FSM states: IDLE, START, WAIT, CAPTURE, RESPOND.
- **IDLE**
  - The round-robin arbiter picks the first valid requester, searching from `rr_ptr`.
  - `req_ready_o` is one-hot for that requester, combinational from `req_valid_i`.
  - On accept, the controller latches the operands and requester id, then sets `rr_ptr = id + 1` (mod NUM_REQ).
  - If divisor == 0: load quotient = all ones, remainder = dividend, `div_by_zero` = 1; go to RESPOND.
  - Else if dividend < divisor: load quotient = 0, remainder = dividend; go to RESPOND.
  - Otherwise go to START.
- **START**
  - Drive the latched operands to the divider and pulse its `data_valid_i` for exactly one cycle; go to WAIT.
- **WAIT**
  - Hold until the divider asserts `data_valid_o`, then go to CAPTURE.
- **CAPTURE**
  - Latch the divider's quotient and remainder. The restored remainder is valid only in this cycle, the cycle after its `data_valid_o`.
  - Go to RESPOND.
- **RESPOND**
  - `resp_valid_o` = 1. Data and id stay stable until `resp_ready_i`; on handshake go to IDLE.
- Requests are never accepted outside IDLE.
- A requester may drop `req_valid_i` before it is granted. Once a request is accepted, it always completes.
- Divider result arithmetic is unsigned; the controller performs no width extension.

## Timing

- Reset (async, `rst_n_i` low):
  - State = IDLE; `rr_ptr` = 0, so requester 0 has the highest priority.
  - `resp_valid_o`, `busy_o`, `div_by_zero_o`, `quotient_o`, `remainder_o` and `resp_id_o` = 0.
  - `req_ready_o` follows `req_valid_i` arbitration immediately after reset release.
- Latency measured from the accept edge T:
  - Bypass cases: `resp_valid_o` high at T+1.
  - Divider case: START at T+1, divider runs DATA_WIDTH cycles plus its restore cycle, CAPTURE at T+DATA_WIDTH+3, `resp_valid_o` high at T+DATA_WIDTH+4.
- After a response handshake, the earliest next accept is in the following cycle (IDLE). There is no accept in the handshake cycle itself.
- Reset mid-division: the controller returns to IDLE, the divider instance resets with the same reset, and the in-flight request is dropped with no response.
- With `clk_en_i` low in RESPOND, outputs hold and `resp_ready_i` is ignored.

## Structure

- Package `divider_arbiter_pkg`: FSM state enum; response struct (id, quotient, remainder, `div_by_zero`).
- One sub-module: `non_restoring_divider #(DATA_WIDTH)`. Its reset is tied to `rst_n_i`, its `clk_en_i` to `clk_en_i`, and its `divide_by_zero_o` is unused.
- The round-robin arbiter is a combinational function inside this module; it is not a separate module.

## Test plan

Parameters for all scenarios: DATA_WIDTH = 16, NUM_REQ = 4.

1. Single request from requester 2, 1000/7 → `resp_id_o` = 2, q = 142, r = 6, `resp_valid_o` at T+20.
2. Requesters 0 and 1 continuously valid, `resp_ready_i` = 1 → grants alternate 0, 1, 0, 1; none starved.
3. Divisor 0 with dividend 0x1234 → at T+1: q = 0xFFFF, r = 0x1234, `div_by_zero_o` = 1; divider never started.
4. 5/9 → at T+1: q = 0, r = 5; 0xFFFF/1 → q = 0xFFFF, r = 0.
5. `resp_ready_i` held low for 10 cycles in RESPOND → outputs stable, `req_ready_o` all 0, new requests wait.
6. `rst_n_i` pulsed low mid-WAIT → outputs 0 asynchronously, no response emitted, the next request completes correctly.

Source files
------------

// File: rtl/divider_arbiter_pkg.sv
// Shared types for the divider arbiter: FSM states and the tagged response payload.
package divider_arbiter_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_ID_WIDTH   = $clog2(DEF_NUM_REQ);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CAPTURE,
    ST_RESPOND
  } state_e;

  // Response payload, sized for the default configuration.
  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]   id;
    logic [DEF_DATA_WIDTH-1:0] quotient;
    logic [DEF_DATA_WIDTH-1:0] remainder;
    logic                      div_by_zero;
  } resp_t;

endpackage

// File: rtl/divider_arbiter_divider.sv
// Unsigned non-restoring divider: DATA_WIDTH iterations, then one remainder-restore cycle.
module non_restoring_divider #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clk_en_i,
  input  logic                  data_valid_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic                  data_valid_o,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o,
  output logic                  divide_by_zero_o
);

  localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

  logic [DATA_WIDTH:0]   acc_q, acc_shift, acc_next, div_ext;
  logic [DATA_WIDTH-1:0] quo_q, div_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  run_q, restore_q, valid_q, dbz_q;

  assign div_ext   = {1'b0, div_q};
  assign acc_shift = {acc_q[DATA_WIDTH-1:0], quo_q[DATA_WIDTH-1]};
  assign acc_next  = acc_q[DATA_WIDTH] ? acc_shift + div_ext : acc_shift - div_ext;

  // Quotient is final with data_valid_o; the remainder is restored on the following edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      restore_q <= 1'b0;
      valid_q   <= 1'b0;
      dbz_q     <= 1'b0;
    end else if (clk_en_i) begin
      valid_q   <= 1'b0;
      restore_q <= 1'b0;
      if (run_q) begin
        acc_q <= acc_next;
        quo_q <= {quo_q[DATA_WIDTH-2:0], ~acc_next[DATA_WIDTH]};
        cnt_q <= cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          run_q     <= 1'b0;
          valid_q   <= 1'b1;
          restore_q <= 1'b1;
        end
      end else if (restore_q) begin
        if (acc_q[DATA_WIDTH]) acc_q <= acc_q + div_ext;
      end else if (data_valid_i) begin
        acc_q <= '0;
        quo_q <= dividend_i;
        div_q <= divisor_i;
        cnt_q <= CNT_WIDTH'(DATA_WIDTH);
        run_q <= 1'b1;
        dbz_q <= (divisor_i == '0);
      end
    end
  end

  assign data_valid_o     = valid_q;
  assign quotient_o       = quo_q;
  assign remainder_o      = acc_q[DATA_WIDTH-1:0];
  assign divide_by_zero_o = dbz_q;

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one non-restoring divider between NUM_REQ clients,
// with zero-divisor and dividend<divisor answered directly from IDLE.
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic                                clk_en_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_dividend_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_divisor_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic                                resp_valid_o,
  input  logic                                resp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]          resp_id_o,
  output logic [DATA_WIDTH-1:0]               quotient_o,
  output logic [DATA_WIDTH-1:0]               remainder_o,
  output logic                                div_by_zero_o,
  output logic                                busy_o
);

  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);

  state_e                state_q;
  logic [ID_WIDTH-1:0]   rr_ptr_q, grant_id, next_ptr;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_dividend, sel_divisor, op_dividend_q, op_divisor_q;
  logic [DATA_WIDTH-1:0] div_quotient, div_remainder;
  logic                  div_start_q, div_done, div_dbz, busy_q, resp_valid_q;
  resp_t                 resp_q;

  // First valid requester at or after ptr, wrapping.
  function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                  input logic [ID_WIDTH-1:0] ptr);
    logic [ID_WIDTH-1:0] pick;
    logic                found;
    int unsigned         idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!found && valid[ID_WIDTH'(idx)]) begin
        pick  = ID_WIDTH'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign grant_id     = rr_pick(req_valid_i, rr_ptr_q);
  assign accept       = (state_q == ST_IDLE) && clk_en_i && (|req_valid_i);
  assign next_ptr     = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);
  assign sel_dividend = req_dividend_i[grant_id];
  assign sel_divisor  = req_divisor_i[grant_id];

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant_id] = 1'b1;
  end

  non_restoring_divider #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_div (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .clk_en_i         (clk_en_i),
    .data_valid_i     (div_start_q),
    .dividend_i       (op_dividend_q),
    .divisor_i        (op_divisor_q),
    .data_valid_o     (div_done),
    .quotient_o       (div_quotient),
    .remainder_o      (div_remainder),
    .divide_by_zero_o (div_dbz)
  );

  // Controller: accept/bypass in IDLE, sequence the divider, hold the result until taken.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      op_dividend_q <= '0;
      op_divisor_q  <= '0;
      div_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_q        <= '0;
    end else if (clk_en_i) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rr_ptr_q      <= next_ptr;
            op_dividend_q <= sel_dividend;
            op_divisor_q  <= sel_divisor;
            resp_q.id     <= DEF_ID_WIDTH'(grant_id);
            busy_q        <= 1'b1;
            if (sel_divisor == '0) begin
              resp_q.quotient    <= '1;
              resp_q.remainder   <= DEF_DATA_WIDTH'(sel_dividend);
              resp_q.div_by_zero <= 1'b1;
              resp_valid_q       <= 1'b1;
              state_q            <= ST_RESPOND;
            end else if (sel_dividend < sel_divisor) begin
              resp_q.quotient    <= '0;
              resp_q.remainder   <= DEF_DATA_WIDTH'(sel_dividend);
              resp_q.div_by_zero <= 1'b0;
              resp_valid_q       <= 1'b1;
              state_q            <= ST_RESPOND;
            end else begin
              resp_q.div_by_zero <= 1'b0;
              div_start_q        <= 1'b1;
              state_q            <= ST_START;
            end
          end
        end
        ST_START: begin
          div_start_q <= 1'b0;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (div_done) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          resp_q.quotient    <= DEF_DATA_WIDTH'(div_quotient);
          resp_q.remainder   <= DEF_DATA_WIDTH'(div_remainder);
          resp_q.div_by_zero <= div_dbz;
          resp_valid_q       <= 1'b1;
          state_q            <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid_o  = resp_valid_q;
  assign busy_o        = busy_q;
  assign resp_id_o     = ID_WIDTH'(resp_q.id);
  assign quotient_o    = DATA_WIDTH'(resp_q.quotient);
  assign remainder_o   = DATA_WIDTH'(resp_q.remainder);
  assign div_by_zero_o = resp_q.div_by_zero;

endmodule
